// File: rtl/level_countdown_timer_if.sv
// Level-controller <-> countdown timer signal bundle.
// The timer takes the slave side; the controller/display side takes master.
interface level_countdown_timer_if;
   logic       start_level;
   logic       enable_timer;
   logic       pause;
   logic       bonus_valid;
   logic [3:0] bonus_tens;
   logic [3:0] bonus_ones;
   logic [3:0] tens;
   logic [3:0] ones;
   logic       one_sec_tick;
   logic       low_time;

   modport master (
      output start_level, enable_timer, pause, bonus_valid, bonus_tens, bonus_ones,
      input  tens, ones, one_sec_tick, low_time
   );

   modport slave (
      input  start_level, enable_timer, pause, bonus_valid, bonus_tens, bonus_ones,
      output tens, ones, one_sec_tick, low_time
   );
endinterface

// File: rtl/level_countdown_timer.sv
// Per-level BCD seconds countdown with a run-gated prescaler and
// saturating BCD time bonuses applied on top of the same-cycle decrement.
module level_countdown_timer #(
   parameter int unsigned CLK_HZ     = 31_500_000,
   parameter int unsigned START_TENS = 6,
   parameter int unsigned START_ONES = 0,
   parameter int unsigned LOW_TENS   = 1
) (
   input  logic                   clk,
   input  logic                   resetN,
   level_countdown_timer_if.slave bus
);

   localparam int unsigned    PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0]  TC = PW'(CLK_HZ - 1);

   logic [3:0]    tens_q, ones_q;
   logic [PW-1:0] presc_q;
   logic          tick_q;

   logic          value_nz, run, tick;
   logic [3:0]    dec_tens, dec_ones;
   logic          dec_nz, carry, bonus_ok;
   logic [4:0]    ones_sum, ones_adj, tens_sum;
   logic [3:0]    nxt_tens, nxt_ones;

   assign value_nz = (tens_q != 4'd0) || (ones_q != 4'd0);
   assign run      = bus.enable_timer && !bus.pause && value_nz;
   assign tick     = run && (presc_q == TC);

   always_comb begin
      dec_tens = tens_q;
      dec_ones = ones_q;
      if (tick) begin
         if (ones_q != 4'd0) begin
            dec_ones = ones_q - 4'd1;
         end else begin
            dec_ones = 4'd9;
            dec_tens = tens_q - 4'd1;
         end
      end
      dec_nz = (dec_tens != 4'd0) || (dec_ones != 4'd0);

      // Bonus is added to the already-decremented value; tens overflow saturates at 99.
      ones_sum = {1'b0, dec_ones} + {1'b0, bus.bonus_ones};
      carry    = ones_sum > 5'd9;
      ones_adj = ones_sum - 5'd10;
      tens_sum = {1'b0, dec_tens} + {1'b0, bus.bonus_tens} + {4'd0, carry};
      bonus_ok = bus.bonus_valid && (bus.bonus_tens <= 4'd9) &&
                 (bus.bonus_ones <= 4'd9) && dec_nz;

      nxt_tens = dec_tens;
      nxt_ones = dec_ones;
      if (bonus_ok) begin
         if (tens_sum > 5'd9) begin
            nxt_tens = 4'd9;
            nxt_ones = 4'd9;
         end else begin
            nxt_tens = tens_sum[3:0];
            nxt_ones = carry ? ones_adj[3:0] : ones_sum[3:0];
         end
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         tens_q  <= '0;
         ones_q  <= '0;
         presc_q <= '0;
         tick_q  <= 1'b0;
      end else if (bus.start_level) begin
         tens_q  <= 4'(START_TENS);
         ones_q  <= 4'(START_ONES);
         presc_q <= '0;
         tick_q  <= 1'b0;
      end else begin
         tens_q <= nxt_tens;
         ones_q <= nxt_ones;
         tick_q <= tick;
         if (run) begin
            presc_q <= tick ? '0 : presc_q + PW'(1);
         end
      end
   end

   assign bus.tens         = tens_q;
   assign bus.ones         = ones_q;
   assign bus.one_sec_tick = tick_q;
   assign bus.low_time     = ({1'b0, tens_q} < 5'(LOW_TENS)) && value_nz;

endmodule

// File: tb/tb_level_countdown_timer.sv
// Randomized and directed bench for level_countdown_timer against an
// integer-seconds reference model.
module tb_level_countdown_timer;

   localparam int unsigned HZ    = 4;
   localparam int          START = 60;

   logic clk;
   logic resetN;
   int   n_checks = 0;
   int   n_errors = 0;

   int   m_val  = 0;
   int   m_pc   = 0;
   int   m_tick = 0;
   int   tick_cnt;

   level_countdown_timer_if intf ();

   level_countdown_timer #(
      .CLK_HZ    (HZ),
      .START_TENS(6),
      .START_ONES(0),
      .LOW_TENS  (1)
   ) dut (
      .clk   (clk),
      .resetN(resetN),
      .bus   (intf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_model();
      check_eq("tens", 32'(intf.tens), 32'(m_val / 10));
      check_eq("ones", 32'(intf.ones), 32'(m_val % 10));
      check_eq("tick", 32'(intf.one_sec_tick), 32'(m_tick));
      check_eq("low_time", 32'(intf.low_time), 32'((m_val < 10) && (m_val != 0)));
   endtask

   // Seconds as an integer; the prescaler as a count of run cycles since the last tick.
   task automatic model_step(input logic st, en, pa, bv, input logic [3:0] bt, bo);
      int add;
      if (st) begin
         m_val  = START;
         m_pc   = 0;
         m_tick = 0;
         return;
      end
      m_tick = 0;
      if (en && !pa && m_val != 0) begin
         m_pc++;
         if (m_pc == HZ) begin
            m_pc   = 0;
            m_val  = m_val - 1;
            m_tick = 1;
         end
      end
      if (bv && bt <= 9 && bo <= 9 && m_val != 0) begin
         add   = 10 * int'(bt) + int'(bo);
         m_val = (m_val + add > 99) ? 99 : m_val + add;
      end
   endtask

   task automatic cycle(input logic st, en, pa, bv, input logic [3:0] bt, bo);
      intf.start_level  = st;
      intf.enable_timer = en;
      intf.pause        = pa;
      intf.bonus_valid  = bv;
      intf.bonus_tens   = bt;
      intf.bonus_ones   = bo;
      @(posedge clk);
      model_step(st, en, pa, bv, bt, bo);
      @(negedge clk);
      check_model();
   endtask

   // Run enabled until the model reaches the value (and prescaler phase if pc >= 0).
   task automatic run_until(input int val, input int pc);
      int n = 0;
      while (!(m_val == val && (pc < 0 || m_pc == pc)) && n < 500) begin
         cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
         n++;
      end
      check_eq("run_until_reached", 32'(m_val == val), 32'd1);
   endtask

   initial begin
      resetN            = 1'b0;
      intf.start_level  = 1'b0;
      intf.enable_timer = 1'b0;
      intf.pause        = 1'b0;
      intf.bonus_valid  = 1'b0;
      intf.bonus_tens   = 4'd0;
      intf.bonus_ones   = 4'd0;
      @(negedge clk);
      check_model();
      resetN = 1'b1;

      // Load and first seconds
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
      check_eq("load_60", {intf.tens, intf.ones}, 8'h60);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
      check_eq("pre_tick", 32'(intf.one_sec_tick), 32'd0);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
      check_eq("first_dec", {intf.tens, intf.ones}, 8'h59);
      check_eq("first_tick", 32'(intf.one_sec_tick), 32'd1);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
      check_eq("second_dec", {intf.tens, intf.ones}, 8'h58);

      // Pause at 45 with prescaler 2
      run_until(45, 2);
      for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
      check_eq("pause_hold", {intf.tens, intf.ones}, 8'h45);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
      check_eq("pause_rel1_tick", 32'(intf.one_sec_tick), 32'd0);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
      check_eq("pause_rel2_val", {intf.tens, intf.ones}, 8'h44);
      check_eq("pause_rel2_tick", 32'(intf.one_sec_tick), 32'd1);

      // Bonus arithmetic with the timer stopped
      run_until(15, -1);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd9);
      check_eq("bonus_15_09", {intf.tens, intf.ones}, 8'h24);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'd6, 4'd1);
      check_eq("bonus_24_61", {intf.tens, intf.ones}, 8'h85);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 4'd0);
      check_eq("bonus_sat", {intf.tens, intf.ones}, 8'h99);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
      run_until(40, -1);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'hA);
      check_eq("bonus_invalid", {intf.tens, intf.ones}, 8'h40);

      // Tick and bonus together, then start and bonus together
      run_until(10, 3);
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd5);
      check_eq("tick_bonus_val", {intf.tens, intf.ones}, 8'h14);
      check_eq("tick_bonus_tick", 32'(intf.one_sec_tick), 32'd1);
      cycle(1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 4'd2);
      check_eq("start_bonus", {intf.tens, intf.ones}, 8'h60);

      // Countdown to zero and stop
      run_until(2, -1);
      check_eq("low_at_02", 32'(intf.low_time), 32'd1);
      run_until(1, -1);
      check_eq("low_at_01", 32'(intf.low_time), 32'd1);
      run_until(0, -1);
      check_eq("low_at_00", 32'(intf.low_time), 32'd0);
      tick_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
         tick_cnt += int'(intf.one_sec_tick);
      end
      check_eq("no_ticks_at_00", 32'(tick_cnt), 32'd0);
      check_eq("stay_00", {intf.tens, intf.ones}, 8'h00);
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 4'd1);
      check_eq("bonus_at_00", {intf.tens, intf.ones}, 8'h00);

      // Asynchronous reset mid-count
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
      run_until(37, -1);
      #2 resetN = 1'b0;
      #1;
      m_val = 0; m_pc = 0; m_tick = 0;
      check_eq("async_rst_val", {intf.tens, intf.ones}, 8'h00);
      check_eq("async_rst_tick", 32'(intf.one_sec_tick), 32'd0);
      @(negedge clk);
      resetN = 1'b1;
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
      check_eq("reload_60", {intf.tens, intf.ones}, 8'h60);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
      check_eq("rst_pre_tick", 32'(intf.one_sec_tick), 32'd0);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
      check_eq("rst_first_dec", {intf.tens, intf.ones}, 8'h59);

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         cycle(logic'($urandom_range(0, 59) == 0),
               logic'($urandom_range(0, 9) != 0),
               logic'($urandom_range(0, 7) == 0),
               logic'($urandom_range(0, 7) == 0),
               4'($urandom_range(0, 11)),
               4'($urandom_range(0, 11)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/level_countdown_timer.md
# level_countdown_timer

Per-level BCD seconds countdown. Produces the `ones`/`tens` digit pair that the timer-end checker consumes, and takes that checker's `enable_timer` back as its run enable. It sits between the level controller (`start_level`, bonus events) and the score/timer display. On `start_level` it loads a start value, then decrements once per second while enabled and not paused. It stops at 00 and supports saturating BCD time bonuses.

## Interface
- CLK_HZ, 31_500_000, clk cycles per second; the prescaler terminal count is CLK_HZ-1; benches override it with a small value.
- START_TENS, 6, BCD tens digit loaded on start_level (0-9).
- START_ONES, 0, BCD ones digit loaded on start_level (0-9).
- LOW_TENS, 1, low_time asserts while tens < LOW_TENS and value != 00.
- clk  in  1  system clock, rising edge.
- resetN  in  1  reset, asynchronous, active-low.
- start_level  in  1  one-cycle pulse: load START value, clear prescaler.
- enable_timer  in  1  run enable, from the timer-end checker.
- pause  in  1  level-sensitive hold.
- bonus_valid  in  1  one-cycle pulse: add bonus_tens:bonus_ones.
- bonus_tens  in  4  BCD bonus tens digit.
- bonus_ones  in  4  BCD bonus ones digit.
- tens  out  4  BCD tens digit, registered.
- ones  out  4  BCD ones digit, registered.
- one_sec_tick  out  1  registered one-cycle pulse on each decrement.
- low_time  out  1  low-time warning, combinational decode of the registered value.

## Operation
- Reset (async): tens=0, ones=0, prescaler=0, one_sec_tick=0. low_time=0 because the value is 00.
- The value is always valid BCD, in the range 00..99.
- run = enable_timer & !pause & (value != 00).
- Prescaler:
  - When run is high, it increments each cycle; at CLK_HZ-1 it wraps to 0 and raises an internal tick.
  - When run is low, it holds its count (it is not cleared).
  - start_level clears it to 0.
- Decrement on tick:
  - ones != 0: ones-1.
  - ones == 0: ones=9, tens-1.
  - A tick is never generated at 00, so the value never wraps to 99.
- Bonus on bonus_valid:
  - Requires both digits <= 9 and the post-decrement value != 00; otherwise the bonus is ignored entirely.
  - BCD add: ones sum > 9 gives ones-10 with a carry into tens; tens sum > 9 saturates the result to 99.
- Priority per cycle, highest first:
  1. start_level: load START, ignore tick and bonus, no one_sec_tick.
  2. Tick decrement.
  3. Bonus added to the decremented value.
- one_sec_tick: high for exactly the one cycle in which the decremented value first appears on tens/ones.
- low_time: (tens < LOW_TENS) & (value != 00).
- Reaching 00 stops the prescaler. The checker sees the 01->00 transition and drops enable_timer; no further ticks occur even if enable stays high.
- start_level while counting: immediate reload, and counting resumes from prescaler 0.

## Timing
- Latency start_level -> value: 1 cycle (the value is registered on the start_level edge).
- First decrement: CLK_HZ cycles of run=1 after the prescaler was cleared; tick cadence is CLK_HZ run-cycles.
- The enable_timer rise lags start_level by 1 cycle. The first second is therefore measured from the enable rise, not from start_level.
- Bonus latency: 1 cycle from the bonus_valid edge to the updated value.
- Pause or enable low for N cycles delays the next tick by exactly N cycles.
- resetN assertion mid-count clears all state immediately; no clock is needed.

## Test plan
- CLK_HZ=4, START 60:
  - Stimulus: reset, pulse start_level, hold enable_timer=1.
  - Required: value 60 one cycle after start_level; 59 after 4 enabled cycles, with one_sec_tick high that cycle; 58 four cycles later.
- Countdown to zero (START 02):
  - Required: 02 -> 01 -> 00 with low_time=1 at 02 and 01, and low_time=0 at 00.
  - Hold enable 20 more cycles: value stays 00 and no further ticks occur.
- Pause at value 45 with prescaler=2, held for 7 cycles:
  - Required: value and prescaler frozen; the next tick lands exactly 2 run-cycles after release, giving 44.
- Bonus cases:
  - 15 + 09 -> 24.
  - 85 + 30 -> 99 (saturation).
  - 40 + 0A -> ignored, stays 40.
  - Bonus at 00 -> ignored.
- Simultaneous events:
  - Tick and bonus 05 at value 10: result 14, one_sec_tick=1.
  - start_level and bonus in the same cycle: result 60.
- Reset mid-count: assert resetN low at value 37 between clock edges.
  - Required: outputs 00, tick 0 immediately.
  - After release and start_level: reload to 60, and the first tick arrives after a full 4 cycles.
